cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Arbitrates between the instruction-cache and data-cache miss paths (each driven by a cache controller's `mem_read`/`mem_write`/`mem_done` outputs) and the single physical-memory port. It sits directly downstream of both cache controllers. It forwards one line-sized transaction at a time and routes `pmem_resp` back only to the granted requester. A D-cache writeback and the refill that follows it are kept atomic, so the I-cache cannot slip in between them.

## Interface
- `ADDR_W`, 16, byte address width.
- `LINE_W`, 128, cache line width in bits.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_mem_read`  in  1  I-cache line read request.
- `i_mem_address`  in  ADDR_W  I-cache line address.
- `i_mem_rdata`  out  LINE_W  read data to the I-cache.
- `i_mem_resp`  out  1  I-cache transaction complete.
- `d_mem_read`, `d_mem_write`  in  1  D-cache refill request / writeback request.
- `d_mem_done`  in  1  D-cache writeback-to-refill gap marker.
- `d_mem_address`  in  ADDR_W  D-cache line address.
- `d_mem_wdata`  in  LINE_W  D-cache writeback data.
- `d_mem_rdata`  out  LINE_W  read data to the D-cache.
- `d_mem_resp`  out  1  D-cache transaction complete.
- `pmem_read`, `pmem_write`  out  1  physical-memory requests.
- `pmem_address`  out  ADDR_W  physical-memory address.
- `pmem_wdata`  out  LINE_W  physical-memory write data.
- `pmem_rdata`  in  LINE_W  physical-memory read data.
- `pmem_resp`  in  1  physical-memory transaction complete.

## Operation
- States: `IDLE`, `SERVE_I`, `SERVE_D`, `D_HOLD`.
- `IDLE`:
  - No `pmem_*` request is driven.
  - If a D request is pending (`d_mem_read|d_mem_write`) and an I request is pending, grant per the priority rule (see Configuration).
  - If only one side is pending, grant that side.
  - Otherwise stay in `IDLE`.
- `SERVE_I`:
  - `pmem_read=i_mem_read`, `pmem_write=0`, `pmem_address=i_mem_address`.
  - `i_mem_resp=pmem_resp`.
  - On `pmem_resp`, go to `IDLE`.
- `SERVE_D`:
  - `pmem_read=d_mem_read`, `pmem_write=d_mem_write`, `pmem_address=d_mem_address`, `pmem_wdata=d_mem_wdata`.
  - `d_mem_resp=pmem_resp`.
  - On `pmem_resp` with `d_mem_write=1`, go to `D_HOLD`.
  - On `pmem_resp` with `d_mem_read=1`, go to `IDLE`.
- `D_HOLD`:
  - No `pmem_*` request is driven. The grant stays with D.
  - If `d_mem_read=1`, go to `SERVE_D`.
  - Else if `d_mem_done=1`, stay in `D_HOLD`.
  - Else (abandoned), go to `IDLE`.
- `i_mem_rdata` and `d_mem_rdata` both equal `pmem_rdata` at all times. Consumers qualify the data with their own resp.
- The resp of the non-granted side is always 0.
- I requests arriving during `SERVE_D`/`D_HOLD` wait; no request is dropped, and a pending request is served once the arbiter returns to `IDLE`.
- Reset, asynchronous, any state:
  - State returns to `IDLE` and `last_grant` returns to I.
  - All `pmem_*` requests, `pmem_address`, `pmem_wdata`, and both resp outputs are 0.
  - An in-flight pmem transaction is abandoned; pmem must be reset with the arbiter.

## Timing
- Arbitration latency: request sampled in `IDLE`; `pmem_*` request asserted in the next cycle (granted `SERVE_*` state).
- `pmem_*` outputs and the resp outputs are combinational from the registered state and the live inputs. There is no extra data latency.
- `pmem_resp` and the granted resp are in the same cycle.
- The cycle after a resp is always `IDLE` or `D_HOLD`, so the requester drops its request before any re-grant.
- Writeback then refill: W resp at cycle t → `D_HOLD` at t+1 (`d_mem_done`) → `SERVE_D` at t+3 once `d_mem_read` is seen at t+2.
- Best case per line: 1 arbitration cycle plus the pmem latency.

## Configuration
- `CACHE_ARB_RR_EN` defined:
  - A 1-bit `last_grant` register, updated on every grant from `IDLE`, decides simultaneous I/D requests in `IDLE`.
  - The side not granted last wins.
  - Grants from `D_HOLD` do not update `last_grant`.
- Undefined:
  - Fixed priority, D wins every tie.
  - `last_grant` is absent.

## Test plan
- I-only read at 0x1230, pmem resp after 3 cycles with rdata 0xA5…A5:
  - `pmem_read` high for 3 cycles, `pmem_address`=0x1230.
  - `i_mem_resp` pulses once with rdata.
  - `d_mem_resp` stays 0.
- Simultaneous I read 0x0100 and D read 0x2000:
  - Fixed build: D is served first, then I.
  - RR build with `last_grant`=D: I is served first.
- D writeback 0x4000 (wdata 0x5A…5A), then mem_done for 1 cycle, then refill 0x4000, with an I request pending throughout:
  - `pmem_write` is asserted first, then `pmem_read`, both at 0x4000.
  - I is not granted until after the D refill resp.
- `D_HOLD` abandon: after W resp, drive `d_mem_done`=0 and `d_mem_read`=0:
  - State is `IDLE` one cycle later.
  - A pending I read is then granted.
- Assert `rst_n`=0 mid-`SERVE_D`:
  - `pmem_write` and `pmem_read` drop immediately, both resps are 0.
  - After release the state is `IDLE` and a new I read is served normally.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache miss paths, one line at a time.
// Define CACHE_ARB_RR_EN for round-robin tie-breaking; by default D wins every tie.
module cache_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic              d_mem_done,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    D_HOLD
  } state_t;

  state_t state;
  state_t state_next;
  logic   d_pending;
  logic   tie_to_d;

  assign d_pending   = d_mem_read | d_mem_write;
  assign i_mem_rdata = pmem_rdata;
  assign d_mem_rdata = pmem_rdata;

`ifdef CACHE_ARB_RR_EN
  // last_grant is 1 when D took the most recent grant out of IDLE; D_HOLD re-grants leave it alone.
  logic last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b0;
    end else if (state == IDLE && state_next != IDLE) begin
      last_grant <= (state_next == SERVE_D);
    end
  end

  assign tie_to_d = ~last_grant;
`else
  assign tie_to_d = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Requests are only driven while a SERVE state owns the port, so reset (forcing IDLE) silences pmem at once.
  always_comb begin
    state_next   = state;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_mem_resp   = 1'b0;
    d_mem_resp   = 1'b0;
    case (state)
      IDLE: begin
        if (d_pending && (!i_mem_read || tie_to_d)) begin
          state_next = SERVE_D;
        end else if (i_mem_read) begin
          state_next = SERVE_I;
        end
      end
      SERVE_I: begin
        pmem_read    = i_mem_read;
        pmem_address = i_mem_address;
        i_mem_resp   = pmem_resp;
        if (pmem_resp) begin
          state_next = IDLE;
        end
      end
      SERVE_D: begin
        pmem_read    = d_mem_read;
        pmem_write   = d_mem_write;
        pmem_address = d_mem_address;
        pmem_wdata   = d_mem_wdata;
        d_mem_resp   = pmem_resp;
        if (pmem_resp) begin
          state_next = d_mem_write ? D_HOLD : IDLE;
        end
      end
      D_HOLD: begin
        if (d_mem_read) begin
          state_next = SERVE_D;
        end else if (!d_mem_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level ownership model of the memory port.
module tb_cache_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk;
  logic              rst_n;
  logic              i_mem_read;
  logic [ADDR_W-1:0] i_mem_address;
  logic [LINE_W-1:0] i_mem_rdata;
  logic              i_mem_resp;
  logic              d_mem_read;
  logic              d_mem_write;
  logic              d_mem_done;
  logic [ADDR_W-1:0] d_mem_address;
  logic [LINE_W-1:0] d_mem_wdata;
  logic [LINE_W-1:0] d_mem_rdata;
  logic              d_mem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int checks = 0;
  int errors = 0;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_done(d_mem_done),
    .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog act=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_inputs();
    i_mem_read    = 1'b0;
    i_mem_address = '0;
    d_mem_read    = 1'b0;
    d_mem_write   = 1'b0;
    d_mem_done    = 1'b0;
    d_mem_address = '0;
    d_mem_wdata   = '0;
    pmem_rdata    = '0;
    pmem_resp     = 1'b0;
  endtask

  task automatic test_reset();
    logic [LINE_W-1:0] rd;
    @(negedge clk);
    rst_n         = 1'b0;
    i_mem_read    = 1'b1;
    d_mem_write   = 1'b1;
    d_mem_address = 16'h1234;
    d_mem_wdata   = rand_line();
    pmem_resp     = 1'b1;
    rd            = rand_line();
    pmem_rdata    = rd;
    #1;
    checks++;
    if ({pmem_read, pmem_write, i_mem_resp, d_mem_resp} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl act=%b exp=0000", {pmem_read, pmem_write, i_mem_resp, d_mem_resp});
    end
    checks++;
    if (pmem_address !== 16'h0 || pmem_wdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data act=%h/%h exp=0/0", pmem_address, pmem_wdata);
    end
    checks++;
    if (i_mem_rdata !== rd || d_mem_rdata !== rd) begin
      errors++;
      $display("[TB] FAIL rdata_pass act=%h/%h exp=%h", i_mem_rdata, d_mem_rdata, rd);
    end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_i_only();
    logic [LINE_W-1:0] a5;
    int high;
    int pulses;
    a5     = {4{32'hA5A5A5A5}};
    high   = 0;
    pulses = 0;
    @(negedge clk);
    i_mem_read    = 1'b1;
    i_mem_address = 16'h1230;
    #1;
    checks++;
    if ({pmem_read, pmem_write, i_mem_resp, d_mem_resp} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL i_only_idle act=%b exp=0000", {pmem_read, pmem_write, i_mem_resp, d_mem_resp});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      pmem_rdata = a5;
      pmem_resp  = (c == 2);
      #1;
      if (pmem_read) high++;
      if (i_mem_resp) pulses++;
      checks++;
      if (pmem_address !== 16'h1230 || pmem_write !== 1'b0) begin
        errors++;
        $display("[TB] FAIL i_only_addr act=%h/%b exp=1230/0", pmem_address, pmem_write);
      end
      checks++;
      if (i_mem_resp !== (c == 2) || d_mem_resp !== 1'b0) begin
        errors++;
        $display("[TB] FAIL i_only_resp cyc=%0d act=%b%b exp=%b0", c, i_mem_resp, d_mem_resp, (c == 2));
      end
    end
    checks++;
    if (i_mem_rdata !== a5) begin
      errors++;
      $display("[TB] FAIL i_only_rdata act=%h exp=%h", i_mem_rdata, a5);
    end
    @(negedge clk);
    i_mem_read = 1'b0;
    pmem_resp  = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0) begin
      errors++;
      $display("[TB] FAIL i_only_release act=%b exp=0", pmem_read);
    end
    checks++;
    if (high != 3 || pulses != 1) begin
      errors++;
      $display("[TB] FAIL i_only_counts act=%0d/%0d exp=3/1", high, pulses);
    end
  endtask

  task automatic test_tie();
    bit first_d;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] second_addr;
`ifdef CACHE_ARB_RR_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    first_addr  = first_d ? 16'h2000 : 16'h0100;
    second_addr = first_d ? 16'h0100 : 16'h2000;
    // A lone D read first, so D was granted last.
    @(negedge clk);
    d_mem_read    = 1'b1;
    d_mem_address = 16'h2800;
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    checks++;
    if ({pmem_read, pmem_write, i_mem_resp, d_mem_resp} !== 4'b1001 || pmem_address !== 16'h2800) begin
      errors++;
      $display("[TB] FAIL tie_prep act=%b@%h exp=1001@2800", {pmem_read, pmem_write, i_mem_resp, d_mem_resp}, pmem_address);
    end
    @(negedge clk);
    d_mem_read = 1'b0;
    pmem_resp  = 1'b0;
    @(negedge clk);
    i_mem_read    = 1'b1;
    i_mem_address = 16'h0100;
    d_mem_read    = 1'b1;
    d_mem_address = 16'h2000;
    #1;
    checks++;
    if (pmem_read !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tie_idle act=%b exp=0", pmem_read);
    end
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (pmem_address !== first_addr || {pmem_read, i_mem_resp, d_mem_resp} !== {1'b1, ~first_d, first_d}) begin
      errors++;
      $display("[TB] FAIL tie_first act=%h/%b%b exp=%h/%b%b", pmem_address, i_mem_resp, d_mem_resp, first_addr, ~first_d, first_d);
    end
    @(negedge clk);
    if (first_d) d_mem_read = 1'b0;
    else i_mem_read = 1'b0;
    pmem_resp = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tie_gap act=%b exp=0", pmem_read);
    end
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (pmem_address !== second_addr || {pmem_read, i_mem_resp, d_mem_resp} !== {1'b1, first_d, ~first_d}) begin
      errors++;
      $display("[TB] FAIL tie_second act=%h/%b%b exp=%h/%b%b", pmem_address, i_mem_resp, d_mem_resp, second_addr, first_d, ~first_d);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_wb_refill();
    logic [LINE_W-1:0] wd;
    logic [LINE_W-1:0] rd;
    wd = {4{32'h5A5A5A5A}};
    rd = rand_line();
    @(negedge clk);
    d_mem_write   = 1'b1;
    d_mem_address = 16'h4000;
    d_mem_wdata   = wd;
    @(negedge clk);
    i_mem_read    = 1'b1;
    i_mem_address = 16'h0300;
    #1;
    checks++;
    if ({pmem_read, pmem_write} !== 2'b01 || pmem_address !== 16'h4000 || pmem_wdata !== wd) begin
      errors++;
      $display("[TB] FAIL wb_write act=%b%b@%h exp=01@4000", pmem_read, pmem_write, pmem_address);
    end
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    checks++;
    if ({i_mem_resp, d_mem_resp} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL wb_wresp act=%b%b exp=01", i_mem_resp, d_mem_resp);
    end
    @(negedge clk);
    pmem_resp   = 1'b0;
    d_mem_write = 1'b0;
    d_mem_done  = 1'b1;
    #1;
    checks++;
    if ({pmem_read, pmem_write, i_mem_resp} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL wb_hold1 act=%b exp=000", {pmem_read, pmem_write, i_mem_resp});
    end
    @(negedge clk);
    d_mem_done = 1'b0;
    d_mem_read = 1'b1;
    #1;
    checks++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL wb_hold2 act=%b%b exp=00", pmem_read, pmem_write);
    end
    @(negedge clk);
    pmem_resp  = 1'b1;
    pmem_rdata = rd;
    #1;
    checks++;
    if ({pmem_read, pmem_write, i_mem_resp, d_mem_resp} !== 4'b1001 || pmem_address !== 16'h4000 || d_mem_rdata !== rd) begin
      errors++;
      $display("[TB] FAIL wb_refill act=%b@%h exp=1001@4000", {pmem_read, pmem_write, i_mem_resp, d_mem_resp}, pmem_address);
    end
    @(negedge clk);
    d_mem_read = 1'b0;
    pmem_resp  = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wb_idle act=%b exp=0", pmem_read);
    end
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    checks++;
    if ({pmem_read, i_mem_resp, d_mem_resp} !== 3'b110 || pmem_address !== 16'h0300) begin
      errors++;
      $display("[TB] FAIL wb_i_after act=%b@%h exp=110@0300", {pmem_read, i_mem_resp, d_mem_resp}, pmem_address);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_abandon();
    @(negedge clk);
    d_mem_write   = 1'b1;
    d_mem_address = 16'h6000;
    d_mem_wdata   = rand_line();
    @(negedge clk);
    pmem_resp     = 1'b1;
    i_mem_read    = 1'b1;
    i_mem_address = 16'h0400;
    #1;
    checks++;
    if ({pmem_write, i_mem_resp, d_mem_resp} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL abandon_wresp act=%b exp=101", {pmem_write, i_mem_resp, d_mem_resp});
    end
    @(negedge clk);
    pmem_resp   = 1'b0;
    d_mem_write = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({pmem_read, pmem_write, i_mem_resp, d_mem_resp} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL abandon_idle act=%b exp=0000", {pmem_read, pmem_write, i_mem_resp, d_mem_resp});
    end
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    checks++;
    if ({pmem_read, i_mem_resp} !== 2'b11 || pmem_address !== 16'h0400) begin
      errors++;
      $display("[TB] FAIL abandon_i act=%b%b@%h exp=11@0400", pmem_read, i_mem_resp, pmem_address);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    d_mem_write   = 1'b1;
    d_mem_read    = 1'b0;
    d_mem_address = 16'h7000;
    d_mem_wdata   = rand_line();
    @(negedge clk);
    #1;
    checks++;
    if (pmem_write !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rmid_pre act=%b exp=1", pmem_write);
    end
    pmem_resp = 1'b1;
    rst_n     = 1'b0;
    #1;
    checks++;
    if ({pmem_read, pmem_write, i_mem_resp, d_mem_resp} !== 4'b0000 || pmem_address !== 16'h0 || pmem_wdata !== '0) begin
      errors++;
      $display("[TB] FAIL rmid_drop act=%b@%h exp=0000@0000", {pmem_read, pmem_write, i_mem_resp, d_mem_resp}, pmem_address);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    i_mem_read    = 1'b1;
    i_mem_address = 16'h0500;
    #1;
    checks++;
    if (pmem_read !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rmid_idle act=%b exp=0", pmem_read);
    end
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    checks++;
    if ({pmem_read, i_mem_resp, d_mem_resp} !== 3'b110 || pmem_address !== 16'h0500) begin
      errors++;
      $display("[TB] FAIL rmid_i act=%b@%h exp=110@0500", {pmem_read, i_mem_resp, d_mem_resp}, pmem_address);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  // Model: the port is free, owned by I, or owned by D; D may also hold it with no transfer in flight.
  task automatic test_random();
    int owner;
    bit held;
    bit last_d;
    bit got_i;
    bit got_d;
    bit win_d;
    bit own_d;
    int dph;
    int gap;
    int pm_age;
    int pm_lat;
    int i_wait;
    int d_wait;
    int max_wait;
    int i_served;
    int d_served;
    int shown;
    logic              e_pr;
    logic              e_pw;
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wd;
    logic              e_ir;
    logic              e_dr;
    owner = 0; held = 0; last_d = 0; got_i = 0; got_d = 0;
    dph = 0; gap = 0; pm_age = 0; pm_lat = 2;
    i_wait = 0; d_wait = 0; max_wait = 0; i_served = 0; d_served = 0; shown = 0;
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (got_i) begin
        i_mem_read = 1'b0;
        i_served++;
      end else if (!i_mem_read && $urandom_range(0, 2) == 0) begin
        i_mem_read    = 1'b1;
        i_mem_address = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFF0;
      end
      if (got_d) begin
        d_served++;
        if (dph == 2) begin
          d_mem_write = 1'b0;
          if ($urandom_range(0, 3) == 0) begin
            dph = 0;
          end else begin
            gap = $urandom_range(0, 3);
            if (gap == 0) begin
              d_mem_read = 1'b1;
              dph = 1;
            end else begin
              d_mem_done = 1'b1;
              dph = 3;
            end
          end
        end else begin
          d_mem_read = 1'b0;
          dph = 0;
        end
      end else if (dph == 3) begin
        gap--;
        if (gap == 0) begin
          d_mem_done = 1'b0;
          d_mem_read = 1'b1;
          dph = 1;
        end
      end else if (dph == 0) begin
        case ($urandom_range(0, 3))
          0: begin
            d_mem_read    = 1'b1;
            d_mem_address = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFF0;
            dph = 1;
          end
          1: begin
            d_mem_write   = 1'b1;
            d_mem_address = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFF0;
            d_mem_wdata   = rand_line();
            dph = 2;
          end
          default: ;
        endcase
      end
      pmem_rdata = rand_line();
      own_d  = (owner == 2) && !held;
      e_pr   = (owner == 1) ? i_mem_read : (own_d ? d_mem_read : 1'b0);
      e_pw   = own_d ? d_mem_write : 1'b0;
      e_addr = (owner == 1) ? i_mem_address : (own_d ? d_mem_address : '0);
      e_wd   = own_d ? d_mem_wdata : '0;
      if (e_pr || e_pw) begin
        pm_age++;
        pmem_resp = (pm_age >= pm_lat);
        if (pmem_resp) begin
          pm_age = 0;
          pm_lat = $urandom_range(1, 4);
        end
      end else begin
        pmem_resp = 1'b0;
      end
      e_ir = (owner == 1) && pmem_resp;
      e_dr = own_d && pmem_resp;
      #1;
      checks++;
      if ({pmem_read, pmem_write, pmem_address, pmem_wdata, i_mem_resp, d_mem_resp} !== {e_pr, e_pw, e_addr, e_wd, e_ir, e_dr}
          || i_mem_rdata !== pmem_rdata || d_mem_rdata !== pmem_rdata) begin
        errors++;
        if (shown < 8) begin
          shown++;
          $display("[TB] FAIL random_cyc%0d act=r%b w%b a%h ir%b dr%b exp=r%b w%b a%h ir%b dr%b",
                   cyc, pmem_read, pmem_write, pmem_address, i_mem_resp, d_mem_resp,
                   e_pr, e_pw, e_addr, e_ir, e_dr);
        end
      end
      got_i = e_ir;
      got_d = e_dr;
      i_wait = i_mem_read ? i_wait + 1 : 0;
      d_wait = (d_mem_read || d_mem_write || d_mem_done) ? d_wait + 1 : 0;
      if (i_wait > max_wait) max_wait = i_wait;
      if (d_wait > max_wait) max_wait = d_wait;
      case (owner)
        0: begin
          if ((d_mem_read || d_mem_write) && i_mem_read) begin
`ifdef CACHE_ARB_RR_EN
            win_d = !last_d;
`else
            win_d = 1'b1;
`endif
          end else begin
            win_d = d_mem_read || d_mem_write;
          end
          if (win_d) begin
            owner = 2;
            last_d = 1'b1;
          end else if (i_mem_read) begin
            owner = 1;
            last_d = 1'b0;
          end
        end
        1: if (pmem_resp) owner = 0;
        default: begin
          if (!held) begin
            if (pmem_resp) begin
              if (d_mem_write) held = 1'b1;
              else owner = 0;
            end
          end else if (d_mem_read) begin
            held = 1'b0;
          end else if (!d_mem_done) begin
            held  = 1'b0;
            owner = 0;
          end
        end
      endcase
    end
    checks++;
    if (max_wait > 80) begin
      errors++;
      $display("[TB] FAIL random_starve act=%0d exp=<=80", max_wait);
    end
    checks++;
    if (i_served == 0 || d_served == 0) begin
      errors++;
      $display("[TB] FAIL random_served act=%0d/%0d exp=nonzero", i_served, d_served);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_i_only();
    test_tie();
    test_wb_refill();
    test_abandon();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
